keyboard_seq_gen: RTL and testbench
===================================

KEYBOARD_SEQ_GEN -- requirements
Module: keyboard_seq_gen

Interface
REQ-001 The block SHALL have parameter N_KEYS, default 3, giving the number of key outputs.
REQ-002 The block SHALL have parameter DEPTH, default 8, giving the number of script entries (power of two, at least 2).
REQ-003 The block SHALL have parameter CTR_W, default 32, giving the width of the hold and gap counters.
REQ-004 The block SHALL have port clk, input, width 1: the single clock; all logic SHALL be rising-edge.
REQ-005 The block SHALL have port rst, input, width 1: reset, asynchronous assert, active-low.
REQ-006 The block SHALL have port wr_en, input, width 1: script write strobe.
REQ-007 The block SHALL have port wr_addr, input, width clog2(DEPTH): script entry index.
REQ-008 The block SHALL have port wr_keys, input, width N_KEYS: key mask for the entry.
REQ-009 The block SHALL have port wr_hold, input, width CTR_W: key-asserted duration in cycles.
REQ-010 The block SHALL have port wr_gap, input, width CTR_W: all-released duration in cycles after the hold.
REQ-011 The block SHALL have port seq_len, input, width clog2(DEPTH)+1: number of entries to play, sampled at start.
REQ-012 The block SHALL have port loop_en, input, width 1: restart from entry 0 after the last entry; sampled at every wrap decision.
REQ-013 The block SHALL have port start, input, width 1: begin playback pulse.
REQ-014 The block SHALL have port abort, input, width 1: stop playback.
REQ-015 The block SHALL have port keys, output, width N_KEYS: registered key levels (1 = pressed).
REQ-016 The block SHALL have port busy, output, width 1: high in HOLD or GAP.
REQ-017 The block SHALL have port done, output, width 1: one-cycle pulse on non-looping completion.
REQ-018 The block SHALL have port entry_idx, output, width clog2(DEPTH): entry currently playing.

Function
REQ-019 Script storage SHALL hold DEPTH entries of {keys, hold, gap}; a write with wr_en=1 SHALL update the entry at wr_addr on that edge, in any state.
REQ-020 A written entry SHALL take effect only when it is next loaded; an entry already playing SHALL NOT change mid-hold or mid-gap.
REQ-021 The FSM SHALL have four states: IDLE, HOLD, GAP, DONE.
REQ-022 In IDLE, if start=1 and seq_len!=0, the FSM SHALL latch seq_len (values above DEPTH SHALL saturate to DEPTH), load entry 0, and enter HOLD on the next edge; if seq_len=0, start SHALL be ignored.
REQ-023 In HOLD, keys SHALL equal the entry mask for exactly hold cycles.
REQ-024 A hold value of 0 SHALL skip HOLD, so keys stay 0 and the FSM goes directly to GAP, or to the next entry if gap is also 0.
REQ-025 In GAP, keys SHALL be 0 for exactly gap cycles; gap=0 SHALL make the next entry's HOLD start the cycle immediately after the last hold cycle.
REQ-026 After the last entry (index seq_len-1) finishes: if loop_en=1, the FSM SHALL load entry 0 with no idle cycle; otherwise it SHALL enter DONE.
REQ-027 DONE SHALL last one cycle with done=1, keys=0, busy=0, then return to IDLE.
REQ-028 An entry with hold=0 and gap=0 SHALL consume exactly one cycle with keys=0; an all-zero looping script therefore SHALL never lock up the FSM.
REQ-029 start while busy or in DONE SHALL be ignored.
REQ-030 abort=1 in any state SHALL force IDLE on the next edge with keys=0 and busy=0, and done SHALL NOT pulse; abort SHALL have priority over start in the same cycle.
REQ-031 entry_idx SHALL wrap from seq_len-1 to 0 when looping and SHALL hold its last value in IDLE.
REQ-032 Counters SHALL be CTR_W bits, unsigned, and count down without wrap-around.

Reset
REQ-033 While rst=0, keys SHALL be 0, busy 0, done 0, entry_idx 0, the state IDLE, and the counters 0; script contents SHALL be undefined after reset.
REQ-034 Reset asserted mid-playback SHALL stop the sequence immediately and asynchronously, and no done pulse SHALL follow.

Verification
REQ-035 N_KEYS=3; entry0={001,hold 4,gap 2}; entry1={100,hold 1,gap 0}; seq_len=2; loop_en=0; start at cycle 10 -> keys=001 in cycles 11-14, 000 in 15-16, 100 in cycle 17; done=1 in cycle 18; busy=1 in cycles 11-17.
REQ-036 Same script with loop_en=1 -> keys=001 resumes in cycle 18 with entry_idx=0 and no done pulse; clearing loop_en during the second pass -> done pulses after that pass.
REQ-037 abort asserted in cycle 13 of the REQ-035 run -> keys=000 and busy=0 from cycle 14, no done pulse; a new start is then accepted.
REQ-038 entry0={010,hold 0,gap 0}, seq_len=1, loop_en=0 -> keys never 1, busy for one cycle, then a done pulse.
REQ-039 Write entry1={111,hold 3,gap 0} while entry0 is in HOLD -> entry1 plays 111 for 3 cycles; start pulsed during playback -> no effect.
REQ-040 rst driven low mid-HOLD between clock edges -> keys=0 without waiting for a clock edge; after rst rises, the block is idle until the next start.

Source files
------------

// File: rtl/keyboard_seq_gen.sv
// keyboard_seq_gen
//   Plays a small script of key presses. Each script entry is
//   {key mask, hold cycles, gap cycles}: the mask is driven on the keys for
//   "hold" cycles, then all keys are released for "gap" cycles. Entries
//   0..seq_len-1 play in order; the script can loop back to entry 0.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-low reset
//   wr_en      script write strobe (accepted in any state)
//   wr_addr    script entry index to write
//   wr_keys    key mask for the written entry
//   wr_hold    key-asserted duration in cycles
//   wr_gap     all-released duration in cycles after the hold
//   seq_len    number of entries to play, sampled at start (saturates at DEPTH)
//   loop_en    restart from entry 0 after the last entry (sampled at each wrap)
//   start      begin-playback pulse (ignored unless idle)
//   abort      stop playback, back to idle on the next edge, no done pulse
//   keys       registered key levels (1 = pressed)
//   busy       high while an entry is playing (HOLD or GAP)
//   done       one-cycle pulse on non-looping completion
//   entry_idx  entry currently playing; holds its last value when idle
//   dbg_state  current FSM state (0 IDLE, 1 HOLD, 2 GAP, 3 DONE)
//
// Handshake: there is no backpressure. start/abort/wr_en are sampled on
// every rising edge; start only takes effect in IDLE with seq_len != 0, and
// abort wins over start when both are high in the same cycle.
module keyboard_seq_gen #(
    parameter int N_KEYS = 3,
    parameter int DEPTH  = 8,
    parameter int CTR_W  = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr,
    input  logic [N_KEYS-1:0]          wr_keys,
    input  logic [CTR_W-1:0]           wr_hold,
    input  logic [CTR_W-1:0]           wr_gap,
    input  logic [$clog2(DEPTH):0]     seq_len,
    input  logic                       loop_en,
    input  logic                       start,
    input  logic                       abort,
    output logic [N_KEYS-1:0]          keys,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(DEPTH)-1:0]   entry_idx,
    output logic [1:0]                 dbg_state
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_V = DEPTH[AW:0];

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Script storage. Deliberately not reset: contents are undefined after reset.
    logic [N_KEYS-1:0] mem_keys [DEPTH];
    logic [CTR_W-1:0]  mem_hold [DEPTH];
    logic [CTR_W-1:0]  mem_gap  [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_keys[wr_addr] <= wr_keys;
            mem_hold[wr_addr] <= wr_hold;
            mem_gap[wr_addr]  <= wr_gap;
        end
    end

    // Playback state. The playing entry's mask and gap are copied out of the
    // script at load time so a concurrent write cannot alter it mid-entry.
    state_t            state_q, state_n;
    logic [AW-1:0]     idx_q, idx_n;
    logic [AW:0]       len_q, len_n;
    logic [CTR_W-1:0]  cnt_q, cnt_n;
    logic [N_KEYS-1:0] cur_keys_q, cur_keys_n;
    logic [CTR_W-1:0]  cur_gap_q, cur_gap_n;
    logic [N_KEYS-1:0] keys_q, keys_n;

    logic              do_load;
    logic [AW-1:0]     load_idx;
    logic              finish;
    logic              last;
    logic [AW:0]       len_sat;

    assign len_sat = (seq_len > DEPTH_V) ? DEPTH_V : seq_len;
    assign last    = (({1'b0, idx_q} + 1'b1) == len_q);

    always_comb begin
        state_n    = state_q;
        idx_n      = idx_q;
        len_n      = len_q;
        cnt_n      = cnt_q;
        cur_keys_n = cur_keys_q;
        cur_gap_n  = cur_gap_q;
        keys_n     = '0;
        do_load    = 1'b0;
        load_idx   = idx_q;
        finish     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && (seq_len != '0)) begin
                    len_n    = len_sat;
                    do_load  = 1'b1;
                    load_idx = '0;
                end
            end
            // cnt holds the cycles remaining including the current one.
            HOLD: begin
                if (cnt_q > 1) begin
                    cnt_n = cnt_q - 1'b1;
                end else if (cur_gap_q != '0) begin
                    state_n = GAP;
                    cnt_n   = cur_gap_q;
                end else begin
                    finish = 1'b1;
                end
            end
            // A GAP entered with cnt=0 is the single cycle consumed by an
            // entry whose hold and gap are both zero.
            GAP: begin
                if (cnt_q > 1) begin
                    cnt_n = cnt_q - 1'b1;
                end else begin
                    finish = 1'b1;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (finish) begin
            if (last) begin
                if (loop_en) begin
                    do_load  = 1'b1;
                    load_idx = '0;
                end else begin
                    state_n = DONE;
                    cnt_n   = '0;
                end
            end else begin
                do_load  = 1'b1;
                load_idx = idx_q + 1'b1;
            end
        end

        // Loading an entry skips straight to GAP when its hold is zero.
        if (do_load) begin
            idx_n      = load_idx;
            cur_keys_n = mem_keys[load_idx];
            cur_gap_n  = mem_gap[load_idx];
            if (mem_hold[load_idx] != '0) begin
                state_n = HOLD;
                cnt_n   = mem_hold[load_idx];
            end else begin
                state_n = GAP;
                cnt_n   = mem_gap[load_idx];
            end
        end

        if (abort) begin
            state_n = IDLE;
            idx_n   = idx_q;
            len_n   = len_q;
            cnt_n   = '0;
        end

        if (state_n == HOLD) begin
            keys_n = cur_keys_n;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            cur_keys_q <= '0;
            cur_gap_q  <= '0;
            keys_q     <= '0;
        end else begin
            state_q    <= state_n;
            idx_q      <= idx_n;
            len_q      <= len_n;
            cnt_q      <= cnt_n;
            cur_keys_q <= cur_keys_n;
            cur_gap_q  <= cur_gap_n;
            keys_q     <= keys_n;
        end
    end

    assign keys      = keys_q;
    assign busy      = (state_q == HOLD) || (state_q == GAP);
    assign done      = (state_q == DONE);
    assign entry_idx = idx_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_keyboard_seq_gen.sv
// Directed testbench for keyboard_seq_gen (N_KEYS=3, DEPTH=8, CTR_W=32).
// The stimulus process pushes one expected output vector per clock cycle;
// the monitor pops and compares on every falling edge.
module tb_keyboard_seq_gen;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HOLD = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [2:0]  wr_keys;
  logic [31:0] wr_hold;
  logic [31:0] wr_gap;
  logic [3:0]  seq_len;
  logic        loop_en;
  logic        start;
  logic        abort;
  logic [2:0]  keys;
  logic        busy;
  logic        done;
  logic [2:0]  entry_idx;
  logic [1:0]  dbg_state;

  // Expected vector: {state, keys, busy, done, entry_idx}
  logic [9:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  keyboard_seq_gen #(.N_KEYS(3), .DEPTH(8), .CTR_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_keys   (wr_keys),
    .wr_hold   (wr_hold),
    .wr_gap    (wr_gap),
    .seq_len   (seq_len),
    .loop_en   (loop_en),
    .start     (start),
    .abort     (abort),
    .keys      (keys),
    .busy      (busy),
    .done      (done),
    .entry_idx (entry_idx),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  function automatic logic [9:0] ev(input logic [1:0] st, input logic [2:0] k,
                                    input logic [2:0] ix);
    logic b;
    logic d;
    b = (st == S_HOLD) || (st == S_GAP);
    d = (st == S_DONE);
    return {st, k, b, d, ix};
  endfunction

  // Immediate check of the live outputs (no clock edge involved)
  task automatic check_now(input string tag, input logic [9:0] e);
    logic [9:0] a;
    a = {dbg_state, keys, busy, done, entry_idx};
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s @%0t: got st=%0d keys=%b busy=%b done=%b idx=%0d, expected st=%0d keys=%b busy=%b done=%b idx=%0d",
               tag, $time, a[9:8], a[7:5], a[4], a[3], a[2:0],
               e[9:8], e[7:5], e[4], e[3], e[2:0]);
    end
  endtask

  // Driver tasks: each call is one clock cycle; inputs set after a call
  // are sampled on the following rising edge.
  task automatic cyc(input logic [9:0] e);
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    wr_en = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic run(input logic [1:0] st, input logic [2:0] k,
                     input logic [2:0] ix, input int n);
    for (int i = 0; i < n; i++) cyc(ev(st, k, ix));
  endtask

  task automatic wr(input logic [2:0] a, input logic [2:0] k,
                    input logic [31:0] h, input logic [31:0] g,
                    input logic [2:0] ix);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_keys = k;
    wr_hold = h;
    wr_gap  = g;
    cyc(ev(S_IDLE, 3'b000, ix));
  endtask

  // Scoreboard monitor
  initial begin
    logic [9:0] e;
    logic [9:0] a;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        a = {dbg_state, keys, busy, done, entry_idx};
        n_vec++;
        if (a !== e) begin
          n_err++;
          $display("FAIL trace vec %0d @%0t: got st=%0d keys=%b busy=%b done=%b idx=%0d, expected st=%0d keys=%b busy=%b done=%b idx=%0d",
                   n_vec, $time, a[9:8], a[7:5], a[4], a[3], a[2:0],
                   e[9:8], e[7:5], e[4], e[3], e[2:0]);
        end
      end
    end
  end

  // Stimulus
  initial begin
    rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_keys = '0;
    wr_hold = '0; wr_gap = '0; seq_len = '0; loop_en = 1'b0;
    start = 1'b0; abort = 1'b0;

    // Reset state
    #1;
    check_now("reset state", ev(S_IDLE, 3'b000, 0));
    run(S_IDLE, 3'b000, 0, 3);
    rst = 1'b1;
    run(S_IDLE, 3'b000, 0, 2);

    // Basic two-entry script, no loop
    wr(0, 3'b001, 4, 2, 0);
    wr(1, 3'b100, 1, 0, 0);
    seq_len = 4'd2;
    start   = 1'b1;
    run(S_HOLD, 3'b001, 0, 4);
    run(S_GAP,  3'b000, 0, 2);
    run(S_HOLD, 3'b100, 1, 1);
    run(S_DONE, 3'b000, 1, 1);
    run(S_IDLE, 3'b000, 1, 2);

    // Looping, then loop_en cleared during the second pass
    loop_en = 1'b1;
    start   = 1'b1;
    run(S_HOLD, 3'b001, 0, 4);
    run(S_GAP,  3'b000, 0, 2);
    run(S_HOLD, 3'b100, 1, 1);
    run(S_HOLD, 3'b001, 0, 1);
    loop_en = 1'b0;
    run(S_HOLD, 3'b001, 0, 3);
    run(S_GAP,  3'b000, 0, 2);
    run(S_HOLD, 3'b100, 1, 1);
    run(S_DONE, 3'b000, 1, 1);
    run(S_IDLE, 3'b000, 1, 2);

    // Abort mid-hold, then a fresh start is accepted
    start = 1'b1;
    run(S_HOLD, 3'b001, 0, 3);
    abort = 1'b1;
    run(S_IDLE, 3'b000, 0, 3);
    start = 1'b1;
    run(S_HOLD, 3'b001, 0, 4);
    run(S_GAP,  3'b000, 0, 2);
    run(S_HOLD, 3'b100, 1, 1);
    run(S_DONE, 3'b000, 1, 1);
    run(S_IDLE, 3'b000, 1, 1);

    // Abort beats start; seq_len=0 start ignored
    start = 1'b1;
    abort = 1'b1;
    run(S_IDLE, 3'b000, 1, 2);
    seq_len = 4'd0;
    start   = 1'b1;
    run(S_IDLE, 3'b000, 1, 2);

    // Writes during playback only affect entries when next loaded;
    // start during playback ignored
    seq_len = 4'd2;
    start   = 1'b1;
    run(S_HOLD, 3'b001, 0, 1);
    wr_en = 1'b1; wr_addr = 3'd1; wr_keys = 3'b111; wr_hold = 32'd3; wr_gap = 32'd0;
    run(S_HOLD, 3'b001, 0, 1);
    wr_en = 1'b1; wr_addr = 3'd0; wr_keys = 3'b110; wr_hold = 32'd2; wr_gap = 32'd1;
    start = 1'b1;
    run(S_HOLD, 3'b001, 0, 2);
    start = 1'b1;
    run(S_GAP,  3'b000, 0, 2);
    run(S_HOLD, 3'b111, 1, 3);
    run(S_DONE, 3'b000, 1, 1);
    run(S_IDLE, 3'b000, 1, 1);

    // hold=0, gap=0 single entry: one busy cycle, keys stay 0, then done
    wr(0, 3'b010, 0, 0, 1);
    seq_len = 4'd1;
    start   = 1'b1;
    run(S_GAP,  3'b000, 0, 1);
    run(S_DONE, 3'b000, 0, 1);
    run(S_IDLE, 3'b000, 0, 2);

    // All-zero looping script keeps stepping; abort stops it
    wr(1, 3'b101, 0, 0, 0);
    seq_len = 4'd2;
    loop_en = 1'b1;
    start   = 1'b1;
    run(S_GAP, 3'b000, 0, 1);
    run(S_GAP, 3'b000, 1, 1);
    run(S_GAP, 3'b000, 0, 1);
    run(S_GAP, 3'b000, 1, 1);
    abort   = 1'b1;
    loop_en = 1'b0;
    run(S_IDLE, 3'b000, 1, 2);

    // seq_len above DEPTH saturates to all 8 entries
    for (int i = 2; i < 8; i++) wr(i[2:0], 3'b011, 0, 0, 1);
    seq_len = 4'd15;
    start   = 1'b1;
    for (int i = 0; i < 8; i++) run(S_GAP, 3'b000, i[2:0], 1);
    run(S_DONE, 3'b000, 7, 1);
    run(S_IDLE, 3'b000, 7, 1);

    // Asynchronous reset mid-hold, then idle until the next start
    wr(0, 3'b001, 4, 2, 7);
    seq_len = 4'd1;
    start   = 1'b1;
    run(S_HOLD, 3'b001, 0, 2);
    @(posedge clk);
    #1;
    #2 rst = 1'b0;
    #1;
    check_now("async reset mid-hold", ev(S_IDLE, 3'b000, 0));
    exp_q.push_back(ev(S_IDLE, 3'b000, 0));
    run(S_IDLE, 3'b000, 0, 2);
    rst = 1'b1;
    run(S_IDLE, 3'b000, 0, 3);
    start = 1'b1;
    run(S_HOLD, 3'b001, 0, 4);
    run(S_GAP,  3'b000, 0, 2);
    run(S_DONE, 3'b000, 0, 1);
    run(S_IDLE, 3'b000, 0, 1);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 8 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL expired wait: %0d expected vectors never compared", exp_q.size());
    end

    // Final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    if (n_err == 0) $display("PASS");
    else            $display("FAIL");
    $finish;
  end

endmodule
